// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory access sequencer.
package mem_pkg;
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;
  localparam logic [2:0] LD_LB   = 3'b100;
  localparam logic [2:0] LD_LH   = 3'b101;
  localparam logic [2:0] LD_LW   = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef enum logic [1:0] {K_NONE, K_ST, K_LD} kind_t;

  // Store code takes precedence over a load code presented in the same request.
  function automatic kind_t dec_kind(input logic [1:0] st, input logic [2:0] ld);
    if (st != ST_NONE)                                 return K_ST;
    else if (ld == LD_LB || ld == LD_LH || ld == LD_LW) return K_LD;
    else                                               return K_NONE;
  endfunction

  function automatic size_t dec_size(input logic [1:0] st, input logic [2:0] ld);
    if (st != ST_NONE)
      return (st == ST_SB) ? SZ_B : (st == ST_SH) ? SZ_H : SZ_W;
    else
      return (ld == LD_LB) ? SZ_B : (ld == LD_LH) ? SZ_H : SZ_W;
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane alignment: masks, shifted store data, split detect, load extract.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  size_t       i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [7:0]  o_m8,
  output logic [63:0] o_d64,
  output logic        o_split,
  output logic [31:0] o_ldata
);
  logic [2:0]  w_bytes;
  logic [31:0] w_wsz;
  logic [31:0] w_sh;

  // Size-dependent mask, store data and byte count; load window shift.
  always_comb begin
    w_bytes = 3'd4;
    w_wsz   = i_wdata;
    o_m8    = 8'h0F << i_off;
    o_ldata = 32'h0;
    w_sh    = 32'({i_hi, i_lo} >> {i_off, 3'b000});
    case (i_size)
      SZ_B: begin
        w_bytes = 3'd1;
        w_wsz   = {24'h0, i_wdata[7:0]};
        o_m8    = 8'h01 << i_off;
        o_ldata = {{24{w_sh[7]}}, w_sh[7:0]};
      end
      SZ_H: begin
        w_bytes = 3'd2;
        w_wsz   = {16'h0, i_wdata[15:0]};
        o_m8    = 8'h03 << i_off;
        o_ldata = {{16{w_sh[15]}}, w_sh[15:0]};
      end
      default: o_ldata = w_sh;
    endcase
    o_d64   = {32'h0, w_wsz} << {i_off, 3'b000};
    o_split = ({1'b0, i_off} + w_bytes) > 3'd4;
  end
endmodule

// File: rtl/mem_access_unit.sv
// Sequences byte/half/word accesses into one or two word-aligned bus beats.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter bit IDLE_DONE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  st_mode,
  input  logic [2:0]  ld_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  state_t      r_state, w_next;
  logic [29:0] r_wa;
  logic [1:0]  r_off;
  logic [31:0] r_wdata, r_lo, r_rdata;
  size_t       r_size;
  kind_t       r_kind;
  kind_t       w_kind;
  logic [7:0]  w_m8;
  logic [63:0] w_d64;
  logic        w_split, w_hs, w_b0, w_b1, w_final;
  logic [31:0] w_ldata, w_lo;

  assign w_kind  = dec_kind(st_mode, ld_mode);
  assign w_b0    = (r_state == S_BEAT0);
  assign w_b1    = (r_state == S_BEAT1);
  assign w_hs    = bus_req && bus_ready;
  assign w_final = w_hs && (w_b1 || !w_split);
  // In BEAT0 the low word is arriving now; in BEAT1 it was captured earlier.
  assign w_lo    = w_b0 ? bus_rdata : r_lo;

  lane_align u_align (
    .i_off   (r_off),
    .i_size  (r_size),
    .i_wdata (r_wdata),
    .i_lo    (w_lo),
    .i_hi    (bus_rdata),
    .o_m8    (w_m8),
    .o_d64   (w_d64),
    .o_split (w_split),
    .o_ldata (w_ldata)
  );

  // Bus outputs derive only from registered state; zero outside a beat.
  assign bus_req   = w_b0 || w_b1;
  assign bus_we    = bus_req && (r_kind == K_ST);
  assign bus_addr  = w_b0 ? {r_wa, 2'b00} : w_b1 ? {r_wa + 30'd1, 2'b00} : 32'h0;
  assign bus_be    = w_b0 ? w_m8[3:0] : w_b1 ? w_m8[7:4] : 4'h0;
  assign bus_wdata = (r_kind != K_ST) ? 32'h0 :
                     w_b0 ? w_d64[31:0] : w_b1 ? w_d64[63:32] : 32'h0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign rdata     = r_rdata;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) begin
                 if (w_kind != K_NONE) w_next = S_BEAT0;
                 else if (IDLE_DONE)   w_next = S_DONE;
               end
      S_BEAT0: if (w_hs) w_next = w_split ? S_BEAT1 : S_DONE;
      S_BEAT1: if (w_hs) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  // Request latch, low-word capture and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa    <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_size  <= SZ_B;
      r_kind  <= K_NONE;
      r_lo    <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_wa    <= addr[31:2];
        r_off   <= addr[1:0];
        r_wdata <= wdata;
        r_size  <= dec_size(st_mode, ld_mode);
        r_kind  <= w_kind;
      end
      if (w_b0 && w_hs) r_lo <= bus_rdata;
      if (w_final && r_kind == K_LD) r_rdata <= w_ldata;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a two-word read responder.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  st_mode = 2'b00;
  logic [2:0]  ld_mode = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, bus_req, bus_we, bus_ready = 1'b1;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [31:0] mem_a0 = '0, mem_d0 = '0, mem_a1 = 32'hFFFF_FFF0, mem_d1 = '0;
  int n_tot = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign bus_rdata = (bus_addr == mem_a1) ? mem_d1 : (bus_addr == mem_a0) ? mem_d0 : 32'h0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .st_mode(st_mode), .ld_mode(ld_mode),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [1:0] st, input logic [2:0] ld,
                     input logic [31:0] a, input logic [31:0] d);
    st_mode = st; ld_mode = ld; addr = a; wdata = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_req", bus_req, 0); chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0); chk("rst_be", bus_be, 0);
    chk("rst_wdata", bus_wdata, 0); chk("rst_rdata", rdata, 0);
    #13 rst_n = 1'b1;
    step();

    // Aligned SW: one beat, done 2 cycles after start
    req(2'b11, 3'b000, 32'h100, 32'hDEADBEEF);
    chk("sw_req", bus_req, 1); chk("sw_we", bus_we, 1);
    chk("sw_addr", bus_addr, 32'h100); chk("sw_be", bus_be, 4'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF); chk("sw_done_early", done, 0);
    step();
    chk("sw_done", done, 1); chk("sw_req_off", bus_req, 0); chk("sw_busy", busy, 1);
    step();
    chk("sw_idle", busy, 0);

    // SB at offset 3
    req(2'b01, 3'b000, 32'h203, 32'h000000A5);
    chk("sb_addr", bus_addr, 32'h200); chk("sb_be", bus_be, 4'h8);
    chk("sb_wdata", bus_wdata, 32'hA5000000);
    step(); chk("sb_done", done, 1);
    step();

    // Split LW at 0x102
    mem_a0 = 32'h100; mem_d0 = 32'h11223344; mem_a1 = 32'h104; mem_d1 = 32'h55667788;
    req(2'b00, 3'b110, 32'h102, 32'h0);
    chk("lw_b0_addr", bus_addr, 32'h100); chk("lw_b0_be", bus_be, 4'hC);
    chk("lw_we", bus_we, 0);
    step();
    chk("lw_b1_addr", bus_addr, 32'h104); chk("lw_b1_be", bus_be, 4'h3);
    chk("lw_b1_done", done, 0);
    step();
    chk("lw_done", done, 1); chk("lw_rdata", rdata, 32'h77881122);
    step();

    // LB with 3 wait states
    mem_a0 = 32'h0; mem_d0 = 32'h000080FF; mem_a1 = 32'hFFFF_FFF0;
    bus_ready = 1'b0;
    req(2'b00, 3'b100, 32'h001, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("lb_req", bus_req, 1); chk("lb_addr", bus_addr, 32'h0);
      chk("lb_be", bus_be, 4'h2); chk("lb_done", done, 0);
      if (i == 3) bus_ready = 1'b1;
      step();
    end
    chk("lb_done_pulse", done, 1); chk("lb_rdata", rdata, 32'hFFFFFF80);
    step();
    chk("lb_rdata_held", rdata, 32'hFFFFFF80);

    // Split SH wrapping the address space
    req(2'b10, 3'b000, 32'hFFFFFFFF, 32'h0000BEEF);
    chk("sh_b0_addr", bus_addr, 32'hFFFFFFFC); chk("sh_b0_be", bus_be, 4'h8);
    chk("sh_b0_data", bus_wdata, 32'hEF000000);
    step();
    chk("sh_b1_addr", bus_addr, 32'h0); chk("sh_b1_be", bus_be, 4'h1);
    chk("sh_b1_data", bus_wdata, 32'h000000BE); chk("sh_b1_we", bus_we, 1);
    step(); chk("sh_done", done, 1);
    step();

    // Store code wins over a simultaneous load code
    req(2'b01, 3'b110, 32'h40, 32'h00000033);
    chk("win_we", bus_we, 1); chk("win_be", bus_be, 4'h1);
    step(); step();

    // Reset during BEAT1 of a split LH
    req(2'b00, 3'b101, 32'h103, 32'h0);
    step();
    chk("rs_in_b1", bus_addr, 32'h104);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_req", bus_req, 0); chk("rs_busy", busy, 0); chk("rs_done", done, 0);
    chk("rs_rdata", rdata, 0);
    #2 rst_n = 1'b1;
    step();
    chk("rs_idle", busy, 0);

    // No-op start: done one cycle later, no bus traffic
    req(2'b00, 3'b000, 32'h500, 32'h0);
    chk("nop_done", done, 1); chk("nop_req", bus_req, 0);
    step();
    chk("nop_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
